sd_card_cmd_responder: RTL and testbench

//  Card-side end of the SD CMD line: receives 48-bit host command frames, checks framing and CRC7,

---
 rtl/sd_card_cmd_responder.sv | 174 +++++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side SD CMD line: frame receive/CRC7 check and R1/R2 response drive
module sd_card_cmd_responder #(
    parameter int NCR_CYCLES   = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         clk_SD,
    input  logic         reset_SD,
    input  logic         CMD_PIN_IN,
    output logic         CMD_PIN_OUT,
    output logic         io_enable_cmd,
    output logic         cmd_valid,
    output logic         cmd_error,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_argument,
    input  logic         resp_req,
    input  logic [1:0]   resp_type,
    input  logic [31:0]  resp_arg,
    input  logic [127:0] resp_long,
    output logic         busy,
    output logic         resp_done
);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_WAIT_RESP, S_NCR, S_TX} state_t;

    localparam logic [7:0] NCR_LAST = 8'(NCR_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(RESP_TIMEOUT - 1);

    state_t         state;
    logic [46:0]    rx_sreg;
    logic [6:0]     crc;
    logic [7:0]     cnt;
    logic [135:0]   tx_sreg;
    logic [7:0]     tx_cnt;
    logic [7:0]     tx_len;
    logic           tx_short;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        crc7_step = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    logic frame_ok;
    logic tx_in_crc;
    logic tx_last;
    logic tx_bit;
    logic emit;

    // The start bit is implicit (it is what got us out of IDLE), so rx_sreg holds bits 46..0.
    assign frame_ok  = rx_sreg[46] && rx_sreg[0] && (rx_sreg[7:1] == crc);
    assign tx_in_crc = tx_short && (tx_cnt >= 8'd40) && (tx_cnt <= 8'd46);
    assign tx_last   = (tx_cnt == tx_len - 8'd1);
    assign tx_bit    = tx_last ? 1'b1 : (tx_in_crc ? crc[6] : tx_sreg[135]);
    assign emit      = (state == S_NCR && cnt == NCR_LAST) || (state == S_TX && tx_cnt != tx_len);

    always_ff @(posedge clk_SD) begin
        if (reset_SD) begin
            state         <= S_IDLE;
            CMD_PIN_OUT   <= 1'b1;
            io_enable_cmd <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_error     <= 1'b0;
            resp_done     <= 1'b0;
            busy          <= 1'b0;
            cmd_index     <= 6'd0;
            cmd_argument  <= 32'd0;
            rx_sreg       <= 47'd0;
            crc           <= 7'd0;
            cnt           <= 8'd0;
            tx_sreg       <= 136'd0;
            tx_cnt        <= 8'd0;
            tx_len        <= 8'd0;
            tx_short      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            resp_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!CMD_PIN_IN) begin
                        state   <= S_RX;
                        busy    <= 1'b1;
                        rx_sreg <= 47'd0;
                        crc     <= 7'd0;
                        cnt     <= 8'd1;
                    end
                end
                S_RX: begin
                    rx_sreg <= {rx_sreg[45:0], CMD_PIN_IN};
                    if (cnt <= 8'd39)
                        crc <= crc7_step(crc, CMD_PIN_IN);
                    if (cnt == 8'd47)
                        state <= S_CHECK;
                    else
                        cnt <= cnt + 8'd1;
                end
                S_CHECK: begin
                    cnt <= 8'd0;
                    if (frame_ok) begin
                        cmd_valid    <= 1'b1;
                        cmd_index    <= rx_sreg[45:40];
                        cmd_argument <= rx_sreg[39:8];
                        state        <= S_WAIT_RESP;
                    end else begin
                        cmd_error <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_req) begin
                        crc    <= 7'd0;
                        cnt    <= 8'd0;
                        tx_cnt <= 8'd0;
                        case (resp_type)
                            2'b01: begin
                                tx_short <= 1'b1;
                                tx_len   <= 8'd48;
                                tx_sreg  <= {2'b00, cmd_index, resp_arg, 8'h00, 88'd0};
                                state    <= S_NCR;
                            end
                            2'b10: begin
                                tx_short <= 1'b0;
                                tx_len   <= 8'd136;
                                tx_sreg  <= {2'b00, 6'h3F, resp_long};
                                state    <= S_NCR;
                            end
                            default: begin
                                resp_done <= 1'b1;
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end
                        endcase
                    end else if (cnt == TO_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_NCR: begin
                    if (!emit)
                        cnt <= cnt + 8'd1;
                end
                S_TX: begin
                    if (tx_cnt == tx_len) begin
                        io_enable_cmd <= 1'b0;
                        CMD_PIN_OUT   <= 1'b1;
                        resp_done     <= 1'b1;
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // The CRC register is reused: fed by the first 40 response bits, then shifted out.
            if (emit) begin
                state         <= S_TX;
                io_enable_cmd <= 1'b1;
                CMD_PIN_OUT   <= tx_bit;
                tx_sreg       <= {tx_sreg[134:0], 1'b0};
                tx_cnt        <= tx_cnt + 8'd1;
                if (tx_in_crc)
                    crc <= {crc[5:0], 1'b0};
                else if (tx_short && tx_cnt < 8'd40)
                    crc <= crc7_step(crc, tx_bit);
            end
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - directed and randomized bench for sd_card_cmd_responder
module tb_sd_card_cmd_responder;

    logic         clk_SD = 1'b0;
    logic         reset_SD;
    logic         CMD_PIN_IN;
    logic         CMD_PIN_OUT;
    logic         io_enable_cmd;
    logic         cmd_valid;
    logic         cmd_error;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic         resp_req;
    logic [1:0]   resp_type;
    logic [31:0]  resp_arg;
    logic [127:0] resp_long;
    logic         busy;
    logic         resp_done;

    always #5 clk_SD = ~clk_SD;

    sd_card_cmd_responder #(.NCR_CYCLES(2), .RESP_TIMEOUT(64)) dut (
        .clk_SD(clk_SD), .reset_SD(reset_SD), .CMD_PIN_IN(CMD_PIN_IN), .CMD_PIN_OUT(CMD_PIN_OUT),
        .io_enable_cmd(io_enable_cmd), .cmd_valid(cmd_valid), .cmd_error(cmd_error),
        .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_req(resp_req),
        .resp_type(resp_type), .resp_arg(resp_arg), .resp_long(resp_long),
        .busy(busy), .resp_done(resp_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int n_done = 0;
    int n_drive = 0;
    logic [5:0]   last_idx;
    logic [31:0]  last_arg;
    logic [135:0] last_cap;

    task automatic tick();
        @(posedge clk_SD);
        #1;
        n_done  += int'(resp_done);
        n_drive += int'(io_enable_cmd);
    endtask

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_div(m), 1'b1};
    endfunction

    function automatic logic [47:0] short_resp(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {m, crc7_div(m), 1'b1};
    endfunction

    task automatic do_frame(input logic [47:0] f, input logic good,
                            input logic [5:0] exp_idx, input logic [31:0] exp_arg);
        for (int i = 47; i >= 0; i--) begin
            CMD_PIN_IN = f[i];
            tick();
        end
        CMD_PIN_IN = 1'b1;
        tick();
        check("cmd_valid", 136'(cmd_valid), 136'(good));
        check("cmd_error", 136'(cmd_error), 136'(!good));
        check("cmd_index", 136'(cmd_index), 136'(exp_idx));
        check("cmd_argument", 136'(cmd_argument), 136'(exp_arg));
    endtask

    task automatic respond(input logic [1:0] t, input logic [31:0] a, input logic [127:0] lng, input int dly);
        int g;
        int n;
        int drive0;
        logic [135:0] cap;
        logic [135:0] exp;
        for (int i = 0; i < dly; i++) tick();
        check("busy_wait", 136'(busy), 136'(1));
        resp_req  = 1'b1;
        resp_type = t;
        resp_arg  = a;
        resp_long = lng;
        drive0    = n_drive;
        tick();
        resp_req = 1'b0;
        resp_arg = $urandom;
        if (t == 2'b01 || t == 2'b10) begin
            g = 0;
            while (!io_enable_cmd && g < 200) begin
                tick();
                g++;
            end
            check("ncr_gap", 136'(g), 136'(2));
            cap = '0;
            n = 0;
            while (io_enable_cmd && n < 200) begin
                cap = {cap[134:0], CMD_PIN_OUT};
                n++;
                tick();
            end
            exp = (t == 2'b01) ? 136'(short_resp(last_idx, a)) : {2'b00, 6'h3F, lng[127:1], 1'b1};
            check("resp_len", 136'(n), (t == 2'b01) ? 136'(48) : 136'(136));
            check("resp_bits", cap, exp);
            check("resp_done", 136'(resp_done), 136'(1));
            check("line_released", 136'({io_enable_cmd, CMD_PIN_OUT}), 136'(2'b01));
            last_cap = cap;
        end else begin
            check("resp_done_none", 136'(resp_done), 136'(1));
            check("no_drive", 136'(n_drive - drive0 + int'(io_enable_cmd)), 136'(0));
        end
    endtask

    initial begin
        logic [47:0]  f;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   t;
        int           d0;
        int           j;
        bit           bad;

        reset_SD = 1'b1;
        CMD_PIN_IN = 1'b1;
        resp_req = 1'b0;
        resp_type = 2'b00;
        resp_arg = '0;
        resp_long = '0;
        last_idx = '0;
        last_arg = '0;
        tick();
        tick();
        check("reset_outputs", 136'({CMD_PIN_OUT, io_enable_cmd, cmd_valid, cmd_error, busy, resp_done}),
              136'(6'b100000));
        check("reset_index_arg", 136'({cmd_index, cmd_argument}), 136'(0));
        reset_SD = 1'b0;
        tick();

        // CMD0, no response
        do_frame(48'h400000000095, 1'b1, 6'd0, 32'd0);
        respond(2'b00, 32'd0, 128'd0, 0);

        // CMD8, short response
        tick();
        do_frame(48'h48000001AA87, 1'b1, 6'd8, 32'h000001AA);
        last_idx = 6'd8;
        last_arg = 32'h1AA;
        respond(2'b01, 32'h000001AA, 128'd0, 0);
        check("cmd8_r7", last_cap, 136'(48'h08000001AA13));

        // good frame, then CMD8 with bad CRC keeps the held index/argument
        idx = 6'd55;
        arg = $urandom;
        do_frame(host_frame(idx, arg), 1'b1, idx, arg);
        last_idx = idx;
        last_arg = arg;
        respond(2'b11, $urandom, 128'd0, 3);
        do_frame(48'h48000001AA85, 1'b0, last_idx, last_arg);
        check("busy_after_error", 136'(busy), 136'(0));

        // CMD2, long response
        do_frame(host_frame(6'd2, 32'd0), 1'b1, 6'd2, 32'd0);
        last_idx = 6'd2;
        last_arg = 32'd0;
        respond(2'b10, 32'd0, 128'hFFEEDDCCBBAA99887766554433221100, 1);

        // timeout with no request; a late request is ignored
        tick();
        idx = 6'($urandom);
        arg = $urandom;
        do_frame(host_frame(idx, arg), 1'b1, idx, arg);
        last_idx = idx;
        last_arg = arg;
        d0 = n_done + n_drive;
        for (int i = 0; i < 32; i++) tick();
        check("busy_waiting", 136'(busy), 136'(1));
        for (int i = 0; i < 32; i++) tick();
        check("busy_timeout", 136'(busy), 136'(0));
        resp_req = 1'b1;
        resp_type = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        resp_req = 1'b0;
        check("timeout_quiet", 136'(n_done + n_drive - d0), 136'(0));

        // reset during long response bit 20
        do_frame(host_frame(6'd2, 32'hA5A5_0F0F), 1'b1, 6'd2, 32'hA5A5_0F0F);
        resp_req = 1'b1;
        resp_type = 2'b10;
        resp_long = {$urandom, $urandom, $urandom, $urandom};
        tick();
        resp_req = 1'b0;
        j = 0;
        while (!io_enable_cmd && j < 20) begin
            tick();
            j++;
        end
        for (int i = 0; i < 20; i++) tick();
        check("tx_active", 136'(io_enable_cmd), 136'(1));
        reset_SD = 1'b1;
        tick();
        reset_SD = 1'b0;
        check("reset_abort", 136'({io_enable_cmd, CMD_PIN_OUT, busy}), 136'(3'b010));
        check("reset_index", 136'(cmd_index), 136'(0));
        last_idx = 6'd0;
        last_arg = 32'd0;
        idx = 6'($urandom);
        arg = $urandom;
        do_frame(host_frame(idx, arg), 1'b1, idx, arg);
        last_idx = idx;
        last_arg = arg;
        respond(2'b01, $urandom, 128'd0, 2);

        // randomized frames and responses
        for (int k = 0; k < 12; k++) begin
            idx = 6'($urandom);
            arg = $urandom;
            f = host_frame(idx, arg);
            bad = ($urandom_range(3) == 0);
            if (bad) begin
                case ($urandom_range(2))
                    0: begin
                        j = $urandom_range(7, 1);
                        f[j] = ~f[j];
                    end
                    1: f[46] = 1'b0;
                    default: f[0] = 1'b0;
                endcase
                do_frame(f, 1'b0, last_idx, last_arg);
            end else begin
                do_frame(f, 1'b1, idx, arg);
                last_idx = idx;
                last_arg = arg;
                t = 2'($urandom);
                respond(t, $urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(8));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
